// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, forwarding selects,
// the EX/MEM control bundle and the forwarding-mux helper.
package mips_pkg;

    // ALU control codes, identical to what the ALU-control decoder emits
    localparam logic [3:0] ALU_SLL = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1010;
    localparam logic [3:0] ALU_SRL = 4'b1111;

    // Forwarding select encoding; 11 behaves like 00 (original operand)
    localparam logic [1:0] FWD_SRC     = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;
    localparam logic [1:0] FWD_SRC_ALT = 2'b11;

    // Control bits carried in the EX/MEM register that must never go stale
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch_taken;
    } ex_mem_ctrl_t;

    // Operand forwarding mux shared by both ALU inputs and the store path
    function automatic logic [31:0] fwd_select(
        input logic [1:0]  sel,
        input logic [31:0] orig,
        input logic [31:0] mem_data,
        input logic [31:0] wb_data
    );
        logic [31:0] value;
        case (sel)
            FWD_MEM:     value = mem_data;
            FWD_WB:      value = wb_data;
            FWD_SRC:     value = orig;
            FWD_SRC_ALT: value = orig;
            default:     value = orig;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS ALU: arithmetic, logic, set-less-than and shifts on a
// DW-bit datapath with wrap-around arithmetic, plus the result-is-zero flag.
module alu_core
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    alu_ctrl,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [4:0]    shamt,
    output logic [DW-1:0] result,
    output logic          zero
);

    logic w_slt;

    assign w_slt = ($signed(a) < $signed(b));

    // Operation select; unlisted codes fall back to addition
    always_comb begin
        result = {DW{1'b0}};
        case (alu_ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {{(DW-1){1'b0}}, w_slt};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            default: result = a + b;
        endcase
    end

    assign zero = (result == {DW{1'b0}});

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: optional operand forwarding, ALU, branch-zero test and
// a valid/ready EX/MEM output register.
// Optional build macro EX_STAGE_FWD_EN adds forwarding select/data ports.
module ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    alu_ctrl,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    input  logic [4:0]    shamt,
    input  logic [DW-1:0] store_data,
`ifdef EX_STAGE_FWD_EN
    input  logic [1:0]    fwd_a_sel,
    input  logic [1:0]    fwd_b_sel,
    input  logic [1:0]    fwd_store_sel,
    input  logic [DW-1:0] mem_fwd_data,
    input  logic [DW-1:0] wb_fwd_data,
`endif
    input  logic [RW-1:0] rd_addr,
    input  logic          reg_write,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          branch,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_zero,
    output logic          out_branch_taken,
    output logic [DW-1:0] out_store_data,
    output logic [RW-1:0] out_rd_addr,
    output logic          out_reg_write,
    output logic          out_mem_read,
    output logic          out_mem_write
);

    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;
    logic [DW-1:0] w_store;
    logic [DW-1:0] w_result;
    logic          w_zero;
    logic          w_in_ready;
    logic          w_capture;
    ex_mem_ctrl_t  w_ctrl_next;

    logic          r_out_valid;
    logic [DW-1:0] r_result;
    logic          r_zero;
    logic [DW-1:0] r_store_data;
    logic [RW-1:0] r_rd_addr;
    ex_mem_ctrl_t  r_ctrl;

`ifdef EX_STAGE_FWD_EN
    assign w_op_a  = fwd_select(fwd_a_sel,     src_a,      mem_fwd_data, wb_fwd_data);
    assign w_op_b  = fwd_select(fwd_b_sel,     src_b,      mem_fwd_data, wb_fwd_data);
    assign w_store = fwd_select(fwd_store_sel, store_data, mem_fwd_data, wb_fwd_data);
`else
    assign w_op_a  = src_a;
    assign w_op_b  = src_b;
    assign w_store = store_data;
`endif

    alu_core #(
        .DW (DW)
    ) u_alu_core (
        .alu_ctrl (alu_ctrl),
        .a        (w_op_a),
        .b        (w_op_b),
        .shamt    (shamt),
        .result   (w_result),
        .zero     (w_zero)
    );

    // The slot can take a new op when it is empty or being drained this cycle
    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_capture  = in_valid & w_in_ready & ~flush;

    assign w_ctrl_next.reg_write    = reg_write;
    assign w_ctrl_next.mem_read     = mem_read;
    assign w_ctrl_next.mem_write    = mem_write;
    assign w_ctrl_next.branch_taken = branch & w_zero;

    // EX/MEM valid flag: flush beats capture, capture beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // EX/MEM data fields: load only on capture so they never toggle needlessly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result     <= {DW{1'b0}};
            r_zero       <= 1'b0;
            r_store_data <= {DW{1'b0}};
            r_rd_addr    <= {RW{1'b0}};
        end else if (w_capture) begin
            r_result     <= w_result;
            r_zero       <= w_zero;
            r_store_data <= w_store;
            r_rd_addr    <= rd_addr;
        end else begin
            r_result     <= r_result;
            r_zero       <= r_zero;
            r_store_data <= r_store_data;
            r_rd_addr    <= r_rd_addr;
        end
    end

    // EX/MEM control bits: cleared on flush so MEM/WB never see a stale enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, branch_taken: 1'b0};
        end else if (flush) begin
            r_ctrl <= '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, branch_taken: 1'b0};
        end else if (w_capture) begin
            r_ctrl <= w_ctrl_next;
        end else begin
            r_ctrl <= r_ctrl;
        end
    end

    assign in_ready         = w_in_ready;
    assign out_valid        = r_out_valid;
    assign out_result       = r_result;
    assign out_zero         = r_zero;
    assign out_store_data   = r_store_data;
    assign out_rd_addr      = r_rd_addr;
    assign out_reg_write    = r_ctrl.reg_write;
    assign out_mem_read     = r_ctrl.mem_read;
    assign out_mem_write    = r_ctrl.mem_write;
    assign out_branch_taken = r_ctrl.branch_taken;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Sits directly downstream of the ALU-control decoder: consumes its 4-bit alu_ctrl, operands and control bits from ID/EX.
- Performs the ALU operation and branch-zero test, then holds the result in a valid/ready EX/MEM register feeding the memory stage.

Parameters:
- DW, 32, datapath width; must be 32.
- RW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX presents an op.
- in_ready  out  1  stage can accept this cycle.
- alu_ctrl  in  4  operation code from the ALU-control decoder.
- src_a  in  DW  rs operand.
- src_b  in  DW  rt or sign-extended immediate.
- shamt  in  5  shift amount.
- store_data  in  DW  rt value for sw.
- rd_addr  in  RW  destination register.
- reg_write, mem_read, mem_write, branch  in  1 each  control bits.
- flush  in  1  kill the registered op and block capture this cycle.
- out_valid  out  1  EX/MEM entry valid.
- out_ready  in  1  MEM stage accepts.
- out_result  out  DW  ALU result.
- out_zero  out  1  result == 0.
- out_branch_taken  out  1  branch & zero.
- out_store_data  out  DW  registered store_data.
- out_rd_addr  out  RW  registered rd_addr.
- out_reg_write, out_mem_read, out_mem_write  out  1 each  registered control bits.

Behaviour:
- alu_ctrl decode (combinational, 32-bit wrap, no overflow trap):
  - 0001 a+b.
  - 0010 a-b.
  - 0100 a&b.
  - 0101 a|b.
  - 0110 a^b.
  - 0111 ~(a|b).
  - 1010 signed a<b ? 1 : 0.
  - 0000 b<<shamt.
  - 1111 b>>shamt, logical.
  - Any other code: a+b.
- zero = (result == 0).
- branch_taken = branch & zero. Branch ops arrive with alu_ctrl 0010.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - Capture when in_valid & in_ready & !flush.
  - out_valid stays high and all outputs stay stable until out_ready is seen.
- Latency: one cycle, capture edge to out_valid. Throughput: one op/cycle when out_ready is held high.
- out_valid next-state priority:
  - flush → 0.
  - Else capture → 1.
  - Else out_valid & out_ready → 0.
  - Else hold.
- Simultaneous capture and drain: the new op replaces the old one with no bubble.
- Flush: on the same edge clears out_valid and drops the in-flight input. Data registers are don't-care, but out_reg_write, out_mem_read, out_mem_write and out_branch_taken are forced to 0 so downstream never sees a stale write enable.
- Reset, asynchronous, may assert mid-transfer: every output register goes to 0, including out_valid, out_result and out_zero. in_ready = 1 once out_valid is 0.
- Data registers load only on capture. They hold otherwise; no gratuitous toggling.

Optional Feature:
- EX_STAGE_FWD_EN defined adds these ports:
  - fwd_a_sel in 2, fwd_b_sel in 2, fwd_store_sel in 2.
  - mem_fwd_data in DW, wb_fwd_data in DW.
- Select encoding: 00 original operand, 01 mem_fwd_data, 10 wb_fwd_data, 11 original.
  - fwd_a_sel and fwd_b_sel choose src_a and src_b before the ALU.
  - fwd_store_sel chooses store_data.
- Macro undefined: these ports do not exist and operands pass straight through. The macro has no other behaviour change.

Decomposition:
- Shared package mips_pkg holds:
  - ALU_ADD=4'b0001, ALU_SUB=4'b0010, ALU_AND=4'b0100, ALU_OR=4'b0101, ALU_XOR=4'b0110, ALU_NOR=4'b0111, ALU_SLT=4'b1010, ALU_SLL=4'b0000, ALU_SRL=4'b1111.
  - FWD_* select constants.
  - The same codes the decoder emits.
- One natural combinational sub-module, alu_core (alu_ctrl, a, b, shamt → result, zero). The ex_stage top holds the forwarding mux and the EX/MEM register with its handshake.

Test Plan:
- Reset with rst_n=0 mid-burst → all outputs 0 immediately, without a clock edge. After release, in_ready=1.
- Arithmetic: ADD a=0x7FFFFFFF b=1 → 0x80000000. SUB a=5 b=5 → 0, out_zero=1; with branch=1, out_branch_taken=1. SLT a=0xFFFFFFFF b=1 → 1.
- Logic and shift: AND/OR/XOR/NOR with 0xF0F0F0F0 and 0x0FF00FF0 → 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00, 0x000F000F. SLL b=1 shamt=31 → 0x80000000. SRL b=0x80000000 shamt=31 → 1. Unknown code 1001, a=2 b=3 → 5.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Then out_ready=1 → the next op is captured on the same edge, with no bubble and no loss.
- Flush: flush=1 while out_valid=1 with reg_write set, and in_valid=1 → next cycle out_valid=0 and out_reg_write=0. The input op is not captured.
- Forwarding (EX_STAGE_FWD_EN): fwd_a_sel=01 mem_fwd_data=10, fwd_b_sel=10 wb_fwd_data=7, ADD → 17. fwd_store_sel=01 → out_store_data=10.
